// File: rtl/branch_resolve_pipe.sv
// -----------------------------------------------------------------------------
// branch_resolve_pipe
//   Carries local branch-predictor metadata alongside the D/E/M datapath
//   pipeline registers. It resolves each branch in E against its fetch-time
//   prediction, raises a same-cycle redirect on a mispredict, and drives the
//   memory-stage training interface of the predictor.
//
// Optional feature macro: BP_STATS_EN
//   When defined, the branch and mispredict statistics counters are built.
//   When undefined, both counter ports are tied to 0.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pcF                          fetch PC (not needed by the predictor path)
//   predict_takeF                predicted direction for pcF
//   pc_hashingF / PHT_indexF     predictor indices used at fetch
//   branchD                      instruction in D is a conditional branch
//   actual_takenE                resolved branch condition in E
//   branch_targetE / pc_plus8E   taken target / fall-through PC
//   stallF/D/E/M, flushD/E/M     hazard-unit pipe controls
//   redirectE / redirect_pcE     mispredict redirect (combinational from E)
//   branchM                      one training strobe per retiring branch
//   BHT_indexM / PHT_indexM      indices of the retiring branch
//   actually_takenM              resolved direction
//   predict_resultM              counter training direction
//   mispredictM                  retiring branch was mispredicted
//   bp_branch_cnt                retired-branch count
//   bp_mispredict_cnt            retired-mispredict count
// -----------------------------------------------------------------------------
module branch_resolve_pipe #(
  parameter int unsigned PHT_INDEX_BITS = 7,
  parameter int unsigned BHT_INDEX_BITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  input  logic                      predict_takeF,
  input  logic [BHT_INDEX_BITS-1:0] pc_hashingF,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      branchD,
  input  logic                      actual_takenE,
  input  logic [31:0]               branch_targetE,
  input  logic [31:0]               pc_plus8E,
  input  logic                      stallF,
  input  logic                      stallD,
  input  logic                      stallE,
  input  logic                      stallM,
  input  logic                      flushD,
  input  logic                      flushE,
  input  logic                      flushM,
  output logic                      redirectE,
  output logic [31:0]               redirect_pcE,
  output logic                      branchM,
  output logic [BHT_INDEX_BITS-1:0] BHT_indexM,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexM,
  output logic                      actually_takenM,
  output logic                      predict_resultM,
  output logic                      mispredictM,
  output logic [31:0]               bp_branch_cnt,
  output logic [31:0]               bp_mispredict_cnt
);

  // D stage registers
  logic                      r_valid_d;
  logic                      r_pred_d;
  logic [BHT_INDEX_BITS-1:0] r_hash_d;
  logic [PHT_INDEX_BITS-1:0] r_pht_d;

  // E stage registers
  logic                      r_valid_e;
  logic                      r_pred_e;
  logic [BHT_INDEX_BITS-1:0] r_hash_e;
  logic [PHT_INDEX_BITS-1:0] r_pht_e;
  logic                      r_branch_e;

  // M stage registers
  logic                      r_valid_m;
  logic                      r_pred_m;
  logic [BHT_INDEX_BITS-1:0] r_hash_m;
  logic [PHT_INDEX_BITS-1:0] r_pht_m;
  logic                      r_branch_m;
  logic                      r_taken_m;
  logic                      r_mispredict_m;

  logic w_mispredict_e;

  // F -> D: a stalled fetch hands D a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_d <= 1'b0;
      r_pred_d  <= 1'b0;
      r_hash_d  <= '0;
      r_pht_d   <= '0;
    end else if (flushD) begin
      r_valid_d <= 1'b0;
    end else if (!stallD) begin
      r_valid_d <= ~stallF;
      r_pred_d  <= predict_takeF;
      r_hash_d  <= pc_hashingF;
      r_pht_d   <= PHT_indexF;
    end
  end

  // D -> E: a stalled D hands E a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_e  <= 1'b0;
      r_pred_e   <= 1'b0;
      r_hash_e   <= '0;
      r_pht_e    <= '0;
      r_branch_e <= 1'b0;
    end else if (flushE) begin
      r_valid_e  <= 1'b0;
    end else if (!stallE) begin
      r_valid_e  <= r_valid_d & ~stallD;
      r_pred_e   <= r_pred_d;
      r_hash_e   <= r_hash_d;
      r_pht_e    <= r_pht_d;
      r_branch_e <= branchD;
    end
  end

  // E -> M: resolution results are captured alongside the metadata
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_m      <= 1'b0;
      r_pred_m       <= 1'b0;
      r_hash_m       <= '0;
      r_pht_m        <= '0;
      r_branch_m     <= 1'b0;
      r_taken_m      <= 1'b0;
      r_mispredict_m <= 1'b0;
    end else if (flushM) begin
      r_valid_m      <= 1'b0;
    end else if (!stallM) begin
      r_valid_m      <= r_valid_e & ~stallE;
      r_pred_m       <= r_pred_e;
      r_hash_m       <= r_hash_e;
      r_pht_m        <= r_pht_e;
      r_branch_m     <= r_branch_e;
      r_taken_m      <= actual_takenE;
      r_mispredict_m <= w_mispredict_e;
    end
  end

  // Resolution in E; zero-latency redirect
  assign w_mispredict_e = r_valid_e & r_branch_e & (r_pred_e ^ actual_takenE);
  assign redirectE      = w_mispredict_e;
  assign redirect_pcE   = actual_takenE ? branch_targetE : pc_plus8E;

  // Training strobe fires only in the cycle the branch leaves M
  assign branchM         = r_valid_m & r_branch_m & ~stallM;
  assign BHT_indexM      = r_hash_m;
  assign PHT_indexM      = r_pht_m;
  assign actually_takenM = r_taken_m;
  assign predict_resultM = r_taken_m;
  assign mispredictM     = r_mispredict_m;

`ifdef BP_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispredict_cnt;

  // Free-running statistics; wrap naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt     <= 32'd0;
      r_mispredict_cnt <= 32'd0;
    end else begin
      if (branchM)
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (branchM & r_mispredict_m)
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign bp_branch_cnt     = r_branch_cnt;
  assign bp_mispredict_cnt = r_mispredict_cnt;
`else
  assign bp_branch_cnt     = 32'd0;
  assign bp_mispredict_cnt = 32'd0;
`endif

  // pcF and the M-stage prediction bit are carried for interface symmetry only
  logic w_unused_sink;
  assign w_unused_sink = ^{pcF, r_pred_m};

endmodule

// File: doc/branch_resolve_pipe.md
# branch_resolve_pipe

Carries branch-predictor metadata from fetch through decode and execute to memory. Resolves each branch in execute against its fetch-time prediction and raises a same-cycle redirect on a mispredict. Drives the memory-stage training interface of the local branch predictor: `branchM`, `BHT_indexM`, `PHT_indexM`, `actually_takenM` and `predict_resultM`. Sits beside the datapath pipeline registers and obeys the same stall and flush controls from the hazard unit.

## Interface
Parameters:
- `PHT_INDEX_BITS`, 7, width of the PHT index carried down the pipe
- `BHT_INDEX_BITS`, 3, width of the BHT index (PC hash) carried down the pipe

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `pcF`  in  32  fetch PC
- `predict_takeF`  in  1  predictor direction for `pcF`
- `pc_hashingF`  in  BHT_INDEX_BITS  BHT index used at fetch
- `PHT_indexF`  in  PHT_INDEX_BITS  PHT index used at fetch
- `branchD`  in  1  decoder: instruction in D is a conditional branch
- `actual_takenE`  in  1  branch condition result from the execute comparator
- `branch_targetE`  in  32  computed branch target
- `pc_plus8E`  in  32  fall-through PC (past the delay slot)
- `stallF`, `stallD`, `stallE`, `stallM`  in  1 each  hold the corresponding pipe register
- `flushD`, `flushE`, `flushM`  in  1 each  invalidate the corresponding pipe register
- `redirectE`  out  1  mispredict in E; fetch must load `redirect_pcE`
- `redirect_pcE`  out  32  corrected PC
- `branchM`  out  1  one-cycle training strobe per retiring branch
- `BHT_indexM`  out  BHT_INDEX_BITS  BHT index of the retiring branch
- `PHT_indexM`  out  PHT_INDEX_BITS  PHT index of the retiring branch
- `actually_takenM`  out  1  resolved direction
- `predict_resultM`  out  1  counter training direction; equals `actually_takenM`
- `mispredictM`  out  1  the retiring branch was mispredicted
- `bp_branch_cnt`, `bp_mispredict_cnt`  out  32 each  statistics (see Configuration)

## Operation
- Three register stages: D, E and M. Each stage holds:
  - `valid`
  - `predict_take`
  - `pc_hash`
  - `pht_index`
  - E and M also hold `is_branch`; M also holds `taken` and `mispredict`.
- F→D captures `{1, predict_takeF, pc_hashingF, PHT_indexF}` when `stallD`=0.
  - If `stallF`=1 and `stallD`=0, D loads a bubble (valid=0).
- D→E captures the D fields plus `is_branch`=`branchD`.
- E→M captures the E fields plus `taken`=`actual_takenE` and `mispredict`=`mispredictE`.
- Per-stage update priority: `rst` > `flushX` (valid←0) > `stallX` (hold) > load.
  - A stage that loads while the previous stage is stalled receives a bubble.
- `mispredictE` = validE & is_branchE & (predict_takeE ≠ actual_takenE).
- `redirectE` = `mispredictE`. This output is combinational from E registers and E inputs.
- `redirect_pcE` = `actual_takenE` ? `branch_targetE` : `pc_plus8E`.
  - When `redirectE`=0 the value is still driven but don't-care.
- The block never flushes itself. The hazard unit issues the flushes on `redirectE`, and the delay slot in D is preserved by the hazard unit.
- `branchM` = validM & is_branchM & ~stallM. It therefore asserts exactly once per branch, in the cycle the branch leaves M.
- `BHT_indexM`, `PHT_indexM`, `actually_takenM`, `predict_resultM` and `mispredictM` are driven from M registers and hold while M holds.
- Non-branch instructions carry metadata but never strobe `branchM` or assert `redirectE`.

## Timing
- Reset values:
  - All valid bits 0; all metadata fields 0.
  - `branchM`, `redirectE`, `mispredictM`, `actually_takenM`, `predict_resultM` are 0.
  - Both counters are 0.
- Latency without stalls:
  - Fetch metadata reaches E 2 cycles after F.
  - The branch reaches M 3 cycles after F.
  - `branchM` asserts in that same cycle.
- Redirect is zero-latency: it is visible in the E cycle, before the clock edge.
- If `flushM` and `stallM` are both 1, the flush wins: the M stage goes invalid and no `branchM` strobe occurs.
- `rst` mid-operation: all in-flight branches are dropped and no training strobe is issued.
- Back-to-back branches produce back-to-back `branchM` pulses, one per cycle.

## Configuration
- `BP_STATS_EN` defined:
  - `bp_branch_cnt` increments on every `branchM` pulse.
  - `bp_mispredict_cnt` increments when `branchM` & `mispredictM`.
  - Both are 32-bit and wrap 0xFFFFFFFF→0.
  - Both clear on `rst`.
- `BP_STATS_EN` undefined: both ports are still present and tied to 0. No counter logic is built.

## Test plan
- Reset: hold `rst` 2 cycles, then one idle cycle → all outputs 0, no `branchM` pulse.
- Correct prediction:
  - Stimulus: `predict_takeF`=1, `PHT_indexF`=0x2A, `pc_hashingF`=5, `branchD`=1, `actual_takenE`=1.
  - Response: `redirectE`=0; 3 cycles after F, `branchM`=1 for one cycle with `PHT_indexM`=0x2A, `BHT_indexM`=5, `predict_resultM`=1, `mispredictM`=0.
- Mispredict not-taken:
  - Stimulus: predicted 1, `actual_takenE`=0, `pc_plus8E`=0xBFC00108.
  - Response: in E, `redirectE`=1 and `redirect_pcE`=0xBFC00108; one cycle later `mispredictM`=1, `actually_takenM`=0.
- Stall in M:
  - Stimulus: branch in M with `stallM`=1 for 3 cycles.
  - Response: `branchM`=0 during the stall, then exactly one pulse when `stallM` drops; indices stable throughout.
- Flush:
  - Stimulus: `flushE`=1 while a mispredicted branch is in D.
  - Response: no `redirectE` for it and no `branchM` later.
- Statistics (`BP_STATS_EN`): 4 branches, 1 mispredicted → `bp_branch_cnt`=4, `bp_mispredict_cnt`=1.
